// File: rtl/divider_if.sv
// Start/busy/done handshake between the EX-stage controller (master) and the divider (slave).
interface divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  modport master (
    output start, sign, ain, bin,
    input  busy, done, quot, rem
  );

  modport slave (
    input  start, sign, ain, bin,
    output busy, done, quot, rem
  );
endinterface

// File: rtl/divider.sv
// Radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional DIVIDER_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass CALC.
module divider #(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  divider_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]    prem_q, prem_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH-1:0]  ain_q, ain_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rem_q, rem_d;

  logic              div0_in, ovf_in;
  logic [WIDTH+1:0]  shifted, diff;

  assign div0_in = (bus.bin == '0);
  assign ovf_in  = bus.sign && (bus.ain == MinInt) && (bus.bin == '1);

  // Extra top bit on the partial remainder keeps the borrow of the trial subtract.
  assign shifted = {prem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {2'b00, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    ain_d   = ain_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    quot_d  = quot_q;
    rem_d   = rem_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          ain_d  = bus.ain;
          dvd_d  = (bus.sign && bus.ain[WIDTH-1]) ? -bus.ain : bus.ain;
          dvs_d  = (bus.sign && bus.bin[WIDTH-1]) ? -bus.bin : bus.bin;
          qneg_d = bus.sign && (bus.ain[WIDTH-1] ^ bus.bin[WIDTH-1]);
          rneg_d = bus.sign && bus.ain[WIDTH-1];
          div0_d = div0_in;
          ovf_d  = ovf_in;
          prem_d = '0;
          cnt_d  = '0;
`ifdef DIVIDER_FAST_SPECIAL_EN
          state_d = (div0_in || ovf_in) ? StFix : StCalc;
`else
          state_d = StCalc;
`endif
        end
      end
      StCalc: begin
        if (!diff[WIDTH+1]) begin
          prem_d = diff[WIDTH:0];
          dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d = shifted[WIDTH:0];
          dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (div0_q) begin
          quot_d = '1;
          rem_d  = ain_q;
        end else if (ovf_q) begin
          quot_d = MinInt;
          rem_d  = '0;
        end else begin
          quot_d = qneg_q ? -dvd_q : dvd_q;
          rem_d  = rneg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      ain_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      ain_q   <= ain_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.quot = quot_q;
  assign bus.rem  = rem_q;
endmodule
